// File: rtl/store_align_unit.sv
// Store aligner: turns one (addr, data, size) store into one or two byte-enabled, lane-placed bus write beats.
// Latency: first beat is valid the cycle after acceptance; done is 2 cycles after accept (single beat) or 3 (split), plus stalls.
// Backpressure: req_ready only in IDLE (one request in flight); beats hold stable while mem_ready is low.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake; req_addr, req_data (right-justified), req_size (0=word,1=half,2=byte,3=reserved)
//   mem_valid/mem_ready             write-beat handshake; mem_addr (word aligned), mem_wdata (big-endian lanes), mem_be
//   done, err                       one-cycle completion pulse; err marks a rejected request
module store_align_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic              done,
    output logic              err
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam logic [LW:0] NB_CNT   = (LW+1)'(NB);
    localparam logic [LW:0] HALF_CNT = (LW+1)'(2);
    localparam logic [LW:0] BYTE_CNT = (LW+1)'(1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic [LW-1:0]     off_q, off_nxt;
    logic [LW:0]       nbytes_q, nbytes_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;

    logic              mem_valid_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [NB-1:0]     mem_be_nxt;
    logic              done_nxt, err_nxt;

    logic [LW-1:0]     req_off;
    logic [ADDR_W-1:0] req_base;
    logic [LW:0]       req_nbytes;
    logic              req_cross, cross_q;

    // Lane k of beat b carries datum byte j = k + b*NB - off when 0 <= j < nbytes.
    function automatic logic [NB-1:0] calc_be(input logic [LW-1:0] off,
                                              input logic [LW:0] nbytes,
                                              input logic second);
        logic [NB-1:0] be;
        int j;
        be = '0;
        for (int k = 0; k < NB; k++) begin
            j = k + (second ? NB : 0) - int'(off);
            if (j >= 0 && j < int'(nbytes))
                be[k] = 1'b1;
        end
        return be;
    endfunction

    // Datum byte j (0 = most significant of the nbytes-wide value) lands in big-endian lane k.
    function automatic logic [DATA_W-1:0] calc_wdata(input logic [DATA_W-1:0] data,
                                                     input logic [LW-1:0] off,
                                                     input logic [LW:0] nbytes,
                                                     input logic second);
        logic [DATA_W-1:0] wd;
        int j;
        wd = '0;
        for (int k = 0; k < NB; k++) begin
            j = k + (second ? NB : 0) - int'(off);
            if (j >= 0 && j < int'(nbytes))
                wd[DATA_W-1-8*k -: 8] = data[8*(int'(nbytes)-1-j) +: 8];
        end
        return wd;
    endfunction

    always_comb begin
        req_off  = req_addr[LW-1:0];
        req_base = {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
        case (req_size)
            2'd0:    req_nbytes = NB_CNT;
            2'd1:    req_nbytes = HALF_CNT;
            default: req_nbytes = BYTE_CNT;
        endcase
        req_cross = ({1'b0, req_off} + req_nbytes) > NB_CNT;
        cross_q   = ({1'b0, off_q} + nbytes_q) > NB_CNT;
    end

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        base_nxt      = base_q;
        off_nxt       = off_q;
        nbytes_nxt    = nbytes_q;
        data_nxt      = data_q;
        mem_valid_nxt = mem_valid;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_be_nxt    = mem_be;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    base_nxt   = req_base;
                    off_nxt    = req_off;
                    nbytes_nxt = req_nbytes;
                    data_nxt   = req_data;
                    if (req_size == 2'd3 || (req_cross && ALLOW_MISALIGNED == 0)) begin
                        state_nxt = RESP;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = BEAT0;
                        mem_valid_nxt = 1'b1;
                        mem_addr_nxt  = req_base;
                        mem_be_nxt    = calc_be(req_off, req_nbytes, 1'b0);
                        mem_wdata_nxt = calc_wdata(req_data, req_off, req_nbytes, 1'b0);
                    end
                end
            end
            BEAT0: begin
                if (mem_valid && mem_ready) begin
                    if (cross_q) begin
                        state_nxt     = BEAT1;
                        // Address wraps modulo 2^ADDR_W by construction.
                        mem_addr_nxt  = base_q + ADDR_W'(NB);
                        mem_be_nxt    = calc_be(off_q, nbytes_q, 1'b1);
                        mem_wdata_nxt = calc_wdata(data_q, off_q, nbytes_q, 1'b1);
                    end else begin
                        state_nxt     = RESP;
                        mem_valid_nxt = 1'b0;
                        mem_be_nxt    = '0;
                        mem_wdata_nxt = '0;
                        done_nxt      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_valid && mem_ready) begin
                    state_nxt     = RESP;
                    mem_valid_nxt = 1'b0;
                    mem_be_nxt    = '0;
                    mem_wdata_nxt = '0;
                    done_nxt      = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            off_q     <= '0;
            nbytes_q  <= '0;
            data_q    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            base_q    <= base_nxt;
            off_q     <= off_nxt;
            nbytes_q  <= nbytes_nxt;
            data_q    <= data_nxt;
            mem_valid <= mem_valid_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_be    <= mem_be_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit (DATA_W=32): directed vectors, stalls, rejects, mid-operation reset, randomized stores.
// Expected beats come from a byte-address model: each datum byte goes to req_addr+j, grouped by bus word.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_store_align_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        done, err;

    logic        s_req_valid, s_req_ready;
    logic        s_mem_valid;
    logic        s_mem_ready = 1'b1;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;
    logic        s_done, s_err;

    int checks = 0;
    int passes = 0;

    int          exp_nb;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_be   [2];
    logic [31:0] exp_wd   [2];

    always #5 clk = ~clk;

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .done(done), .err(err)
    );

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_strict (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(s_mem_valid), .mem_ready(s_mem_ready),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_be(s_mem_be),
        .done(s_done), .err(s_err)
    );

    // Reference: scatter each datum byte to its byte address, then group by bus word.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int          nbytes;
        logic [31:0] base, ba, w, bv;
        int          idx;
        nbytes = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        base   = {a[31:2], 2'b00};
        exp_nb = 1;
        exp_addr[0] = base;
        exp_addr[1] = base + 32'd4;
        exp_be[0] = '0; exp_be[1] = '0;
        exp_wd[0] = '0; exp_wd[1] = '0;
        for (int j = 0; j < nbytes; j++) begin
            ba  = a + j;
            w   = {ba[31:2], 2'b00};
            idx = (w == base) ? 0 : 1;
            if (idx == 1) exp_nb = 2;
            bv  = (d >> (8 * (nbytes - 1 - j))) & 32'hFF;
            exp_be[idx][ba[1:0]] = 1'b1;
            exp_wd[idx] = exp_wd[idx] | (bv << (8 * (3 - int'(ba[1:0]))));
        end
    endtask

    task automatic set_exp(input int nb, input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                           input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1);
        exp_nb = nb;
        exp_addr[0] = a0; exp_be[0] = b0; exp_wd[0] = w0;
        exp_addr[1] = a1; exp_be[1] = b1; exp_wd[1] = w1;
    endtask

    // Drives one store on the permissive DUT and checks every beat, stall stability and done timing
    // against exp_* (which the caller fills). Starts and ends on a falling edge with the DUT idle.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input int stall);
        int guard;
        req_addr = a; req_data = d; req_size = sz; req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) $display("FAIL accept_wait a=%h req_ready=%b required 1", a, req_ready);
        else passes++;
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < exp_nb; b++) begin
            checks++;
            if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, exp_addr[b], exp_be[b], exp_wd[b]})
                $display("FAIL beat%0d a=%h sz=%0d got v=%b addr=%h be=%b wd=%h required v=1 addr=%h be=%b wd=%h",
                         b, a, sz, mem_valid, mem_addr, mem_be, mem_wdata, exp_addr[b], exp_be[b], exp_wd[b]);
            else passes++;
            checks++;
            if ({req_ready, done} !== 2'b00)
                $display("FAIL busy_flags beat%0d got req_ready=%b done=%b required 0 0", b, req_ready, done);
            else passes++;
            mem_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                checks++;
                if ({mem_valid, mem_addr, mem_be, mem_wdata, req_ready} !== {1'b1, exp_addr[b], exp_be[b], exp_wd[b], 1'b0})
                    $display("FAIL stall_hold beat%0d cyc%0d got v=%b addr=%h be=%b wd=%h rdy=%b required v=1 addr=%h be=%b wd=%h rdy=0",
                             b, s, mem_valid, mem_addr, mem_be, mem_wdata, req_ready, exp_addr[b], exp_be[b], exp_wd[b]);
                else passes++;
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
        end
        checks++;
        if ({done, err, mem_valid, mem_be} !== {1'b1, 1'b0, 1'b0, 4'b0000})
            $display("FAIL done_pulse a=%h got done=%b err=%b v=%b be=%b required 1 0 0 0000", a, done, err, mem_valid, mem_be);
        else passes++;
        @(negedge clk);
        checks++;
        if ({done, req_ready} !== 2'b01)
            $display("FAIL done_width got done=%b req_ready=%b required 0 1", done, req_ready);
        else passes++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, mem_valid, done, err} !== 4'b1000)
            $display("FAIL reset_flags got rdy=%b v=%b done=%b err=%b required 1 0 0 0", req_ready, mem_valid, done, err);
        else passes++;
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== {32'h0, 32'h0, 4'h0})
            $display("FAIL reset_bus got addr=%h wd=%h be=%b required 0 0 0", mem_addr, mem_wdata, mem_be);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        set_exp(1, 32'h100, 4'b1111, 32'hAABBCCDD, 32'h0, 4'b0, 32'h0);
        drive_store(32'h100, 32'hAABBCCDD, 2'd0, 0);
        set_exp(1, 32'h100, 4'b1000, 32'h000000EE, 32'h0, 4'b0, 32'h0);
        drive_store(32'h103, 32'h000000EE, 2'd2, 0);
        set_exp(1, 32'h100, 4'b1100, 32'h00001234, 32'h0, 4'b0, 32'h0);
        drive_store(32'h102, 32'h00001234, 2'd1, 0);
        set_exp(2, 32'h100, 4'b1000, 32'h00000012, 32'h104, 4'b0001, 32'h34000000);
        drive_store(32'h103, 32'h00001234, 2'd1, 0);
        set_exp(2, 32'hFFFFFFFC, 4'b1100, 32'h0000AABB, 32'h0, 4'b0011, 32'hCCDD0000);
        drive_store(32'hFFFFFFFE, 32'hAABBCCDD, 2'd0, 0);
    endtask

    task automatic test_stall;
        set_exp(1, 32'h200, 4'b1111, 32'h11223344, 32'h0, 4'b0, 32'h0);
        drive_store(32'h200, 32'h11223344, 2'd0, 3);
        set_exp(2, 32'h300, 4'b1110, 32'h00556677, 32'h304, 4'b0001, 32'h88000000);
        drive_store(32'h301, 32'h55667788, 2'd0, 3);
    endtask

    task automatic test_reserved;
        req_addr = 32'h100; req_data = 32'hDEADBEEF; req_size = 2'd3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({done, err, mem_valid, mem_be} !== {1'b1, 1'b1, 1'b0, 4'b0})
            $display("FAIL reserved_resp got done=%b err=%b v=%b be=%b required 1 1 0 0000", done, err, mem_valid, mem_be);
        else passes++;
        @(negedge clk);
        checks++;
        if ({done, err, mem_valid, req_ready} !== 4'b0001)
            $display("FAIL reserved_after got done=%b err=%b v=%b rdy=%b required 0 0 0 1", done, err, mem_valid, req_ready);
        else passes++;
    endtask

    task automatic test_strict;
        // Boundary-crossing word and halfword are rejected without any beat.
        for (int t = 0; t < 2; t++) begin
            req_addr = (t == 0) ? 32'h101 : 32'h103;
            req_size = (t == 0) ? 2'd0 : 2'd1;
            req_data = 32'hCAFEF00D;
            s_req_valid = 1'b1;
            @(negedge clk);
            s_req_valid = 1'b0;
            checks++;
            if ({s_done, s_err, s_mem_valid} !== 3'b110)
                $display("FAIL strict_reject%0d got done=%b err=%b v=%b required 1 1 0", t, s_done, s_err, s_mem_valid);
            else passes++;
            @(negedge clk);
            checks++;
            if ({s_done, s_mem_valid, s_req_ready} !== 3'b001)
                $display("FAIL strict_after%0d got done=%b v=%b rdy=%b required 0 0 1", t, s_done, s_mem_valid, s_req_ready);
            else passes++;
        end
        // Non-crossing halfword still goes through as one beat.
        req_addr = 32'h102; req_size = 2'd1; req_data = 32'hFFFF1234;
        s_req_valid = 1'b1;
        @(negedge clk);
        s_req_valid = 1'b0;
        checks++;
        if ({s_mem_valid, s_mem_addr, s_mem_be, s_mem_wdata} !== {1'b1, 32'h100, 4'b1100, 32'h00001234})
            $display("FAIL strict_beat got v=%b addr=%h be=%b wd=%h required 1 100 1100 00001234",
                     s_mem_valid, s_mem_addr, s_mem_be, s_mem_wdata);
        else passes++;
        @(negedge clk);
        checks++;
        if ({s_done, s_err, s_mem_valid} !== 3'b100)
            $display("FAIL strict_done got done=%b err=%b v=%b required 1 0 0", s_done, s_err, s_mem_valid);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        req_addr = 32'h103; req_data = 32'h00001234; req_size = 2'd1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if ({mem_valid, mem_addr, mem_be} !== {1'b1, 32'h104, 4'b0001})
            $display("FAIL midrst_beat1 got v=%b addr=%h be=%b required 1 104 0001", mem_valid, mem_addr, mem_be);
        else passes++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_valid, mem_be, req_ready, done, err} !== {1'b0, 4'b0, 1'b1, 1'b0, 1'b0})
            $display("FAIL midrst_state got v=%b be=%b rdy=%b done=%b err=%b required 0 0000 1 0 0",
                     mem_valid, mem_be, req_ready, done, err);
        else passes++;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) $display("FAIL midrst_nodone got done pulse required none");
        else passes++;
        model(32'h400, 32'h0BADF00D, 2'd0);
        drive_store(32'h400, 32'h0BADF00D, 2'd0, 0);
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        logic [1:0]  sz;
        for (int i = 0; i < 150; i++) begin
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            d  = $urandom;
            sz = 2'($urandom_range(0, 2));
            model(a, d, sz);
            drive_store(a, d, sz, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

    initial begin
        req_valid = 1'b0; s_req_valid = 1'b0; mem_ready = 1'b0;
        req_addr = '0; req_data = '0; req_size = '0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_stall;
        test_reserved;
        test_strict;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
